// File: rtl/lu_scoreboard_stall_pkg.sv
// Shared sizes and unit IDs for the long-latency scoreboard and its arbiter.
package lu_scoreboard_stall_pkg;

  localparam int LU_REG_ADDR_W = 5;
  localparam int LU_NUM_REGS   = 1 << LU_REG_ADDR_W;
  localparam int LU_NUM_UNITS  = 2;

  typedef enum logic [0:0] {
    UNIT_MUL = 1'b0,
    UNIT_DIV = 1'b1
  } unit_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lu_scoreboard_stall_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module rr_arbiter
  import lu_scoreboard_stall_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          any;
  int            idx;

  always_comb begin
    gnt  = '0;
    gidx = '0;
    any  = 1'b0;
    idx  = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gidx     = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/lu_scoreboard_stall.sv
// Decode-stage hazard unit: pending-register scoreboard, per-unit occupancy,
// shared writeback arbitration and a saturating stall counter.
module lu_scoreboard_stall
  import lu_scoreboard_stall_pkg::*;
#(
  parameter int REG_ADDR_W = LU_REG_ADDR_W,
  parameter int NUM_REGS   = LU_NUM_REGS,
  parameter int NUM_UNITS  = LU_NUM_UNITS,
  parameter int UNIT_W     = clog2_min1(LU_NUM_UNITS),
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [REG_ADDR_W-1:0]           id_rs1,
  input  logic                            id_rs1_en,
  input  logic [REG_ADDR_W-1:0]           id_rs2,
  input  logic                            id_rs2_en,
  input  logic [REG_ADDR_W-1:0]           id_rd,
  input  logic                            id_rd_en,
  input  logic                            id_lu_req,
  input  logic [UNIT_W-1:0]               id_lu_sel,
  input  logic [NUM_UNITS-1:0]            lu_wb_req,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] lu_wb_rd,
  output logic [NUM_UNITS-1:0]            lu_wb_gnt,
  output logic                            pipe_stall,
  output logic [NUM_REGS-1:0]             pend_vec,
  output logic [CNT_W-1:0]                stall_cnt,
  input  logic                            stall_cnt_clr,
  output logic                            err_underflow
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic [OCC_W-1:0]      occ [NUM_UNITS];
  logic [REG_ADDR_W-1:0] wb_rd [NUM_UNITS];
  logic [NUM_UNITS-1:0]  inc_vec;
  logic [NUM_UNITS-1:0]  occ_zero;
  logic                  raw;
  logic                  waw;
  logic                  struct_hz;
  logic                  wbs;
  logic                  fire;
  logic                  underflow;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (lu_wb_req),
    .gnt (lu_wb_gnt)
  );

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      wb_rd[u] = lu_wb_rd[u*REG_ADDR_W +: REG_ADDR_W];
    end
  end

  assign raw        = (id_rs1_en && pend[id_rs1]) || (id_rs2_en && pend[id_rs2]);
  assign waw        = id_rd_en && pend[id_rd];
  assign struct_hz  = id_lu_req && (occ[id_lu_sel] == OCC_W'(DEPTH));
  // The register-file write port is taken, so even a bubble in decode must hold.
  assign wbs        = |lu_wb_gnt;
  assign pipe_stall = wbs || (id_valid && (raw || waw || struct_hz));
  assign fire       = id_valid && id_lu_req && !pipe_stall;
  assign pend_vec   = pend;

  always_comb begin
    inc_vec  = '0;
    occ_zero = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      inc_vec[u]  = fire && (id_lu_sel == UNIT_W'(u));
      occ_zero[u] = (occ[u] == '0);
    end
  end

  assign underflow = |(lu_wb_gnt & ~inc_vec & occ_zero);

  // Clears first so a same-cycle set of the same register wins.
  always_comb begin
    pend_nxt = pend;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (lu_wb_gnt[u]) pend_nxt[wb_rd[u]] = 1'b0;
    end
    if (fire && id_rd_en && (id_rd != '0)) pend_nxt[id_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_UNITS; u++) occ[u] <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (inc_vec[u] && !lu_wb_gnt[u]) begin
          occ[u] <= occ[u] + OCC_W'(1);
        end else if (lu_wb_gnt[u] && !inc_vec[u] && !occ_zero[u]) begin
          occ[u] <= occ[u] - OCC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (underflow) begin
      err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (pipe_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        assert (!(fire && id_rd_en && lu_wb_gnt[u] && (wb_rd[u] == id_rd)));
      end
    end
  end

endmodule

// File: tb/tb_lu_scoreboard_stall.sv
// Directed and random stimulus for lu_scoreboard_stall against a queue-based reference model.
module tb_lu_scoreboard_stall;
  import lu_scoreboard_stall_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic        id_rs1_en = 1'b0;
  logic [4:0]  id_rs2 = '0;
  logic        id_rs2_en = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_rd_en = 1'b0;
  logic        id_lu_req = 1'b0;
  logic [0:0]  id_lu_sel = '0;
  logic [1:0]  lu_wb_req = '0;
  logic [9:0]  lu_wb_rd = '0;
  logic [1:0]  lu_wb_gnt;
  logic        pipe_stall;
  logic [31:0] pend_vec;
  logic [3:0]  stall_cnt;
  logic        stall_cnt_clr = 1'b0;
  logic        err_underflow;

  lu_scoreboard_stall #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_lu_req(id_lu_req), .id_lu_sel(id_lu_sel),
    .lu_wb_req(lu_wb_req), .lu_wb_rd(lu_wb_rd), .lu_wb_gnt(lu_wb_gnt),
    .pipe_stall(pipe_stall), .pend_vec(pend_vec), .stall_cnt(stall_cnt),
    .stall_cnt_clr(stall_cnt_clr), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model: set of pending registers, outstanding-op count and result FIFO per unit.
  logic [31:0] pend_m;
  int          occ_m [2];
  int          rr_m;
  int          cnt_m;
  logic        err_m;
  int          qd [2][8];
  int          qh [2];
  int          qn [2];
  int          wb_prob;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    pend_m = '0;
    rr_m   = 0;
    cnt_m  = 0;
    err_m  = 1'b0;
    for (int u = 0; u < 2; u++) begin
      occ_m[u] = 0;
      qh[u]    = 0;
      qn[u]    = 0;
    end
  endtask

  task automatic raise(input int u);
    lu_wb_req[u]         = 1'b1;
    lu_wb_rd[u*5 +: 5]   = 5'(qd[u][qh[u]]);
  endtask

  task automatic cycle();
    logic [1:0] ge;
    logic       st;
    logic       fire;
    int         g;
    int         u;
    int         r;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < 2; k++) begin
      u = (rr_m + k) % 2;
      if (g < 0 && lu_wb_req[u]) g = u;
    end
    ge = '0;
    if (g >= 0) ge[g] = 1'b1;
    st = (g >= 0) ||
         (id_valid && ((id_rs1_en && pend_m[id_rs1]) || (id_rs2_en && pend_m[id_rs2]) ||
                       (id_rd_en && pend_m[id_rd]) || (id_lu_req && occ_m[id_lu_sel] == DEPTH)));
    check("gnt", 64'(lu_wb_gnt), 64'(ge));
    check("stall", 64'(pipe_stall), 64'(st));
    check("pend", 64'(pend_vec), 64'(pend_m));
    check("cnt", 64'(stall_cnt), 64'(cnt_m));
    check("err", 64'(err_underflow), 64'(err_m));
    fire = id_valid && id_lu_req && !st;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      r = int'(lu_wb_rd[g*5 +: 5]);
      pend_m[r] = 1'b0;
      if (occ_m[g] == 0) err_m = 1'b1;
      else occ_m[g]--;
      rr_m = (g + 1) % 2;
      lu_wb_req[g] = 1'b0;
      if (qn[g] > 0) begin
        qh[g] = (qh[g] + 1) % 8;
        qn[g]--;
      end
    end
    if (fire) begin
      u = int'(id_lu_sel);
      if (id_rd_en && id_rd != 0) pend_m[id_rd] = 1'b1;
      occ_m[u]++;
      qd[u][(qh[u] + qn[u]) % 8] = id_rd_en ? int'(id_rd) : 0;
      qn[u]++;
    end
    if (stall_cnt_clr) cnt_m = 0;
    else if (st && cnt_m < 15) cnt_m++;
    for (int k = 0; k < 2; k++) begin
      if (!lu_wb_req[k] && qn[k] > 0 && int'($urandom_range(0, 99)) < wb_prob) raise(k);
    end
  endtask

  task automatic set_id(input logic v, input int rs1, input logic rs1_en, input int rd,
                        input logic rd_en, input logic lu, input int sel);
    id_valid  = v;
    id_rs1    = 5'(rs1);
    id_rs1_en = rs1_en;
    id_rs2    = '0;
    id_rs2_en = 1'b0;
    id_rd     = 5'(rd);
    id_rd_en  = rd_en;
    id_lu_req = lu;
    id_lu_sel = 1'(sel);
  endtask

  task automatic idle();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic drain();
    idle();
    wb_prob = 100;
    for (int k = 0; k < 2; k++) if (!lu_wb_req[k] && qn[k] > 0) raise(k);
    repeat (10) cycle();
    wb_prob = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    lu_wb_req = '0;
    #1;
    model_reset();
    check("rst_pend", 64'(pend_vec), 64'(0));
    check("rst_cnt", 64'(stall_cnt), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));
    check("rst_gnt", 64'(lu_wb_gnt), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    wb_prob = 0;
    model_reset();
    do_reset();

    // MUL writes x5, reader of x5 waits for the writeback and goes the cycle after.
    set_id(1'b1, 0, 1'b0, 5, 1'b1, 1'b1, UNIT_MUL);
    cycle();
    check("pend5_set", 64'(pend_vec[5]), 64'(1));
    set_id(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    repeat (2) cycle();
    raise(0);
    cycle();
    check("pend5_clr", 64'(pend_vec[5]), 64'(0));
    cycle();

    // Third back-to-back MUL hits the occupancy limit.
    set_id(1'b1, 0, 1'b0, 1, 1'b1, 1'b1, UNIT_MUL);
    cycle();
    set_id(1'b1, 0, 1'b0, 2, 1'b1, 1'b1, UNIT_MUL);
    cycle();
    set_id(1'b1, 0, 1'b0, 3, 1'b1, 1'b1, UNIT_MUL);
    repeat (2) cycle();
    check("struct_hold", 64'(pend_vec[3]), 64'(0));
    raise(0);
    repeat (2) cycle();
    check("struct_go", 64'(pend_vec[3:1]), 64'(3'b110));
    drain();

    // Both units hold results; four back-to-back writebacks alternate and all stall.
    set_id(1'b1, 0, 1'b0, 1, 1'b1, 1'b1, UNIT_MUL);
    cycle();
    set_id(1'b1, 0, 1'b0, 2, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    set_id(1'b1, 0, 1'b0, 3, 1'b1, 1'b1, UNIT_MUL);
    cycle();
    set_id(1'b1, 0, 1'b0, 4, 1'b1, 1'b1, UNIT_DIV);
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;
    idle();
    raise(0);
    raise(1);
    wb_prob = 100;
    repeat (4) cycle();
    wb_prob = 0;
    check("wb_stall_cnt", 64'(stall_cnt), 64'(4));
    check("wb_pend_empty", 64'(pend_vec), 64'(0));

    // rd=x0 to DIV never goes pending; x0 reader not stalled; completion still counts.
    set_id(1'b1, 0, 1'b0, 0, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    check("x0_pend", 64'(pend_vec), 64'(0));
    set_id(1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 0);
    cycle();
    drain();
    check("x0_no_err", 64'(err_underflow), 64'(0));

    // Writeback from an empty DIV unit.
    lu_wb_req[1]  = 1'b1;
    lu_wb_rd[9:5] = 5'd9;
    cycle();
    check("udf_set", 64'(err_underflow), 64'(1));
    repeat (3) cycle();
    check("udf_sticky", 64'(err_underflow), 64'(1));
    set_id(1'b1, 0, 1'b0, 11, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    set_id(1'b1, 0, 1'b0, 12, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    check("udf_occ0", 64'(pend_vec[12:11]), 64'(2'b11));
    drain();

    // Long RAW stall saturates the 4-bit counter; clear wins over a stall.
    set_id(1'b1, 0, 1'b0, 8, 1'b1, 1'b1, UNIT_MUL);
    cycle();
    set_id(1'b1, 8, 1'b1, 0, 1'b0, 1'b0, 0);
    repeat (20) cycle();
    check("cnt_sat", 64'(stall_cnt), 64'(4'hF));
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;
    check("cnt_clr", 64'(stall_cnt), 64'(0));
    drain();

    // Reset lands while a DIV op is outstanding.
    set_id(1'b1, 0, 1'b0, 10, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    idle();
    #2;
    do_reset();
    set_id(1'b1, 0, 1'b0, 13, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    set_id(1'b1, 0, 1'b0, 14, 1'b1, 1'b1, UNIT_DIV);
    cycle();
    check("rst_occ0", 64'(pend_vec[14:13]), 64'(2'b11));
    drain();

    // Random traffic against the model.
    wb_prob = 40;
    for (int n = 0; n < 2000; n++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs1_en     = 1'($urandom_range(0, 1));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rs2_en     = 1'($urandom_range(0, 1));
      id_rd         = 5'($urandom_range(0, 7));
      id_rd_en      = 1'($urandom_range(0, 1));
      id_lu_req     = 1'($urandom_range(0, 1));
      id_lu_sel     = 1'($urandom_range(0, 1));
      stall_cnt_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end
    stall_cnt_clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
